disp_scan_ctrl: RTL and testbench

- Scan controller for the calculator's 4-digit multiplexed 7-segment display.
- Rotates a walking-zero anode pattern, reset value 4'b1110, one digit per scan slot.
- Inserts a blanking gap between digits to prevent ghosting.
- Selects and hex-decodes the matching nibble of the result value, with optional leading-zero blanking and tear-free frame latching.

---
 rtl/disp_scan_ctrl_pkg.sv | 20 ++
 rtl/disp_scan_ctrl_if.sv | 24 ++
 rtl/disp_scan_ctrl_anode_sr.sv | 24 ++
 rtl/disp_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/disp_scan_ctrl_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment scan controller.
package disp_scan_ctrl_pkg;

    localparam logic [3:0] ANODE_RESET = 4'b1110;
    localparam logic [6:0] SEG_BLANK   = 7'h7F;

    typedef enum logic {
        ST_SHOW = 1'b0,
        ST_GAP  = 1'b1
    } scan_state_e;

    // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F
    localparam logic [6:0] HEX_SEG [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Host-side inputs and display-side outputs of the scan controller.
interface disp_scan_ctrl_if;

    logic        run;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    modport master (
        output run, value, dp, blank_lz,
        input  an, seg, dp_n, digit_idx, frame_tick
    );

    modport slave (
        input  run, value, dp, blank_lz,
        output an, seg, dp_n, digit_idx, frame_tick
    );

endinterface

// File: rtl/disp_scan_ctrl_anode_sr.sv
// 4-bit anode shift register; reset_i also serves as the resync load.
module disp_scan_ctrl_anode_sr
    import disp_scan_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       en_i,
    input  logic       si_i,
    output logic [3:0] q_o
);

    logic [3:0] q_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_q <= ANODE_RESET;
        end else if (en_i) begin
            q_q <= {q_q[2:0], si_i};
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/disp_scan_ctrl.sv
// Digit scan controller: walking-zero anodes, blanking gap, frame-latched hex decode.
//
// state   | meaning
// ST_SHOW | one anode low, digit lit for PRESCALE cycles
// ST_GAP  | all anodes off for GAP cycles before rotating to the next digit
module disp_scan_ctrl
    import disp_scan_ctrl_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int GAP      = 8,
    parameter int CNT_W    = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    disp_scan_ctrl_if.slave        bus_if
);

    localparam bit              HAS_GAP  = (GAP > 0);
    localparam logic [CNT_W-1:0] PS_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      lat_value_q, lat_value_d;
    logic [3:0]       lat_dp_q, lat_dp_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_n_q, dp_n_d;
    logic             frame_tick_q, frame_tick_d;

    logic [3:0]       pat;
    logic             rotate;
    logic             pat_ok;
    logic             wrap;

    // Digit k is a leading zero when it and every higher nibble are zero; digit 0 never is.
    function automatic logic [6:0] digit_seg(input logic [15:0] v, input logic [1:0] k,
                                             input logic blz);
        logic [3:0] nib;
        logic       lead_zero;
        nib = v[4*k +: 4];
        unique case (k)
            2'd3:    lead_zero = (v[15:12] == 4'h0);
            2'd2:    lead_zero = (v[15:8] == 8'h00);
            2'd1:    lead_zero = (v[15:4] == 12'h000);
            default: lead_zero = 1'b0;
        endcase
        return (blz && lead_zero) ? SEG_BLANK : HEX_SEG[nib];
    endfunction

    disp_scan_ctrl_anode_sr u_anode_sr (
        .clk_i   (clk_i),
        .reset_i (reset_i || (rotate && !pat_ok)),
        .en_i    (rotate && pat_ok),
        .si_i    (pat[3]),
        .q_o     (pat)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        lat_value_d  = lat_value_q;
        lat_dp_d     = lat_dp_q;
        an_d         = an_q;
        seg_d        = seg_q;
        dp_n_d       = dp_n_q;
        frame_tick_d = 1'b0;
        rotate       = 1'b0;

        if (bus_if.run) begin
            unique case (state_q)
                ST_SHOW: begin
                    if (cnt_q == PS_LAST) begin
                        cnt_d = '0;
                        if (HAS_GAP) begin
                            state_d = ST_GAP;
                            an_d    = 4'hF;
                            seg_d   = SEG_BLANK;
                            dp_n_d  = 1'b1;
                        end else begin
                            rotate = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d  = '0;
                        rotate = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end

        // A corrupted or out-of-step pattern resyncs to digit 0 and is treated as a wrap.
        pat_ok = (pat == ~(4'b0001 << idx_q));
        wrap   = rotate && (!pat_ok || (idx_q == 2'd3));

        if (rotate) begin
            state_d = ST_SHOW;
            idx_d   = wrap ? 2'd0 : idx_q + 2'd1;
            an_d    = pat_ok ? {pat[2:0], pat[3]} : ANODE_RESET;
            if (wrap) begin
                lat_value_d  = bus_if.value;
                lat_dp_d     = bus_if.dp;
                frame_tick_d = 1'b1;
            end
            seg_d  = digit_seg(lat_value_d, idx_d, bus_if.blank_lz);
            dp_n_d = ~lat_dp_d[idx_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_SHOW;
            cnt_q        <= '0;
            idx_q        <= '0;
            lat_value_q  <= '0;
            lat_dp_q     <= '0;
            an_q         <= ANODE_RESET;
            seg_q        <= HEX_SEG[0];
            dp_n_q       <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            lat_value_q  <= lat_value_d;
            lat_dp_q     <= lat_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus_if.an         = an_q;
    assign bus_if.seg        = seg_q;
    assign bus_if.dp_n       = dp_n_q;
    assign bus_if.digit_idx  = idx_q;
    assign bus_if.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench: a slot-arithmetic display model feeds per-cycle expectations for two gap settings.
module tb_disp_scan_ctrl;

    localparam int P  = 4;
    localparam int G0 = 1;
    localparam int G1 = 0;

    localparam logic [6:0] GLYPH [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp_n;
        logic [1:0] idx;
        logic       ft;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blank_lz;

    int n_assert = 0;
    int n_fail   = 0;

    obs_t q0[$];
    obs_t q1[$];

    int         r    [2];
    logic [15:0] lv  [2];
    logic [3:0]  ld  [2];
    logic [6:0]  sseg[2];
    logic        sdpn[2];
    logic        ft  [2];

    always #5 clk = ~clk;

    disp_scan_ctrl_if if0 ();
    disp_scan_ctrl_if if1 ();

    assign if0.run = run;      assign if1.run = run;
    assign if0.value = value;  assign if1.value = value;
    assign if0.dp = dp;        assign if1.dp = dp;
    assign if0.blank_lz = blank_lz;
    assign if1.blank_lz = blank_lz;

    disp_scan_ctrl #(.PRESCALE(P), .GAP(G0), .CNT_W(16)) dut0 (
        .clk_i(clk), .reset_i(reset), .bus_if(if0)
    );
    disp_scan_ctrl #(.PRESCALE(P), .GAP(G1), .CNT_W(16)) dut1 (
        .clk_i(clk), .reset_i(reset), .bus_if(if1)
    );

    function automatic logic [6:0] ref_seg(input logic [15:0] v, input int d, input logic blz);
        logic [15:0] hi;
        logic [3:0]  nib;
        hi  = v >> (4 * d);
        nib = hi[3:0];
        if (blz && d > 0 && hi == 16'h0) return 7'h7F;
        return GLYPH[nib];
    endfunction

    // Display state is a pure function of run-cycles since reset: slot = r/(P+g), lit while r%(P+g) < P.
    task automatic model_step(input int i, input int g);
        int   slot;
        int   ph;
        int   d;
        obs_t e;
        if (reset) begin
            r[i] = 0; lv[i] = 16'h0; ld[i] = 4'h0; ft[i] = 1'b0;
            sseg[i] = GLYPH[0]; sdpn[i] = 1'b1;
        end else if (run) begin
            r[i] = r[i] + 1;
            ft[i] = ((r[i] % (4 * (P + g))) == 0);
            if (ft[i]) begin
                lv[i] = value;
                ld[i] = dp;
            end
            if ((r[i] % (P + g)) == 0) begin
                d = (r[i] / (P + g)) % 4;
                sseg[i] = ref_seg(lv[i], d, blank_lz);
                sdpn[i] = ~ld[i][d];
            end
        end else begin
            ft[i] = 1'b0;
        end
        slot  = r[i] / (P + g);
        ph    = r[i] % (P + g);
        d     = slot % 4;
        e.idx = d[1:0];
        e.ft  = ft[i];
        if (ph < P) begin
            e.an   = ~(4'b0001 << d);
            e.seg  = sseg[i];
            e.dp_n = sdpn[i];
        end else begin
            e.an   = 4'hF;
            e.seg  = 7'h7F;
            e.dp_n = 1'b1;
        end
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    always @(posedge clk) begin
        model_step(0, G0);
        model_step(1, G1);
    end

    task automatic check(input string nm, input obs_t a, input obs_t e);
        n_assert++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s t=%0t got an=%b seg=%b dp_n=%b idx=%0d ft=%b required an=%b seg=%b dp_n=%b idx=%0d ft=%b",
                     nm, $time, a.an, a.seg, a.dp_n, a.idx, a.ft, e.an, e.seg, e.dp_n, e.idx, e.ft);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0)
            check("gap1_out", {if0.an, if0.seg, if0.dp_n, if0.digit_idx, if0.frame_tick}, q0.pop_front());
        if (q1.size() > 0)
            check("gap0_out", {if1.an, if1.seg, if1.dp_n, if1.digit_idx, if1.frame_tick}, q1.pop_front());
    end

    task automatic wait_an(input logic [3:0] target);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (if0.an === target) begin
                n_assert++;
                return;
            end
        end
        n_assert++;
        n_fail++;
        $display("FAIL wait_an t=%0t got an=%b required an=%b within 100 cycles", $time, if0.an, target);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; value = 16'h0; dp = 4'h0; blank_lz = 1'b0;
        cycles(3);
        reset = 1'b0; run = 1'b1; value = 16'h1234;
        cycles(60);
        value = 16'hABCD;
        cycles(50);
        blank_lz = 1'b1; value = 16'h0005;
        cycles(50);
        value = 16'h0000;
        cycles(50);
        blank_lz = 1'b0; value = 16'h1234; dp = 4'b0100;
        cycles(50);
        wait_an(4'b1011);
        run = 1'b0;
        cycles(10);
        run = 1'b1;
        cycles(30);
        wait_an(4'hF);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(30);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0:       value = 16'($urandom);
                    1:       value = 16'($urandom) & 16'h00FF;
                    2:       value = 16'($urandom) & 16'h000F;
                    default: value = 16'h0;
                endcase
            end
            if ($urandom_range(0, 15) == 0) dp = 4'($urandom);
            if ($urandom_range(0, 40) == 0) blank_lz = ~blank_lz;
            run   = ($urandom_range(0, 9) != 0);
            reset = ($urandom_range(0, 499) == 0);
            cycles(1);
        end
        reset = 1'b0; run = 1'b1;
        cycles(5);
        #1;
        n_assert++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain got q0=%0d q1=%0d required 0 0", q0.size(), q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
